// File: rtl/rv32i_pkg.sv
// RV32I shared decode definitions: opcodes, ALU operations, immediate formats and the
// ID/EX pipeline register layout.
package rv32i_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    ImmI = 3'd0,
    ImmS = 3'd1,
    ImmB = 3'd2,
    ImmU = 3'd3,
    ImmJ = 3'd4
  } imm_fmt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    alu_op_t     alu_op;
    logic        wr_rd;
    logic        illegal;
    logic        clk_en;
  } id_ex_t;

  // Shared OP / OP-IMM selection; SUB only exists in the register form, since for OP-IMM
  // bit 30 belongs to the immediate.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic f7b5,
                                              input logic is_reg);
    alu_op_t op;
    op = AluAdd;
    unique case (funct3)
      3'b000:  op = (is_reg && f7b5) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = f7b5 ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      3'b111:  op = AluAnd;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational RV32I immediate generator: builds the sign-extended 32-bit immediate for
// the requested instruction format.
module decode_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (fmt)
      ImmI: imm = {{20{instr[31]}}, instr[31:20]};
      ImmS: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU: imm = {instr[31:12], 12'b0};
      ImmJ: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage with ID/EX pipeline register, stall/flush handling and register-file
// address steering. Optional illegal-instruction checking via DECODE_ILLEGAL_CHECK_EN.
module decode
  import rv32i_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_clk_en,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  regfile_rs1_addr,
  output logic [4:0]  regfile_rs2_addr,
  output logic [31:0] decode_pc,
  output logic [4:0]  decode_rs1_addr,
  output logic [4:0]  decode_rs2_addr,
  output logic [4:0]  decode_rd_addr,
  output logic [31:0] decode_imm,
  output logic [6:0]  decode_opcode,
  output logic [2:0]  decode_funct3,
  output logic [3:0]  decode_alu_op,
  output logic        decode_wr_rd,
  output logic        decode_illegal,
  output logic        decode_clk_en
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  imm_fmt_t    imm_fmt;
  alu_op_t     alu_op;
  logic        writes_rd;
  logic        illegal;
  logic [31:0] imm;

  id_ex_t id_ex_d, id_ex_q;

  assign opcode = fetch_instr[6:0];
  assign funct3 = fetch_instr[14:12];
  assign rd     = fetch_instr[11:7];

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic [6:0] funct7;
  assign funct7 = fetch_instr[31:25];
`endif

  always_comb begin
    imm_fmt   = ImmI;
    alu_op    = AluAdd;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    unique case (opcode)
      OpLui: begin
        imm_fmt   = ImmU;
        alu_op    = AluPassB;
        writes_rd = 1'b1;
      end
      OpAuipc: begin
        imm_fmt   = ImmU;
        writes_rd = 1'b1;
      end
      OpJal: begin
        imm_fmt   = ImmJ;
        writes_rd = 1'b1;
      end
      OpJalr: begin
        writes_rd = 1'b1;
`ifdef DECODE_ILLEGAL_CHECK_EN
        illegal = (funct3 != 3'b000);
`endif
      end
      OpBranch: begin
        imm_fmt = ImmB;
        alu_op  = AluSub;
`ifdef DECODE_ILLEGAL_CHECK_EN
        illegal = (funct3[2:1] == 2'b01);
`endif
      end
      OpLoad: begin
        writes_rd = 1'b1;
`ifdef DECODE_ILLEGAL_CHECK_EN
        illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
`endif
      end
      OpStore: begin
        imm_fmt = ImmS;
`ifdef DECODE_ILLEGAL_CHECK_EN
        illegal = (funct3 > 3'd2);
`endif
      end
      OpImm: begin
        writes_rd = 1'b1;
        alu_op    = alu_from_funct3(funct3, fetch_instr[30], 1'b0);
`ifdef DECODE_ILLEGAL_CHECK_EN
        // Shift-immediate forms reuse the top of the immediate as funct7.
        if (funct3 == 3'b001) begin
          illegal = (funct7 != 7'h00);
        end else if (funct3 == 3'b101) begin
          illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
`endif
      end
      OpReg: begin
        writes_rd = 1'b1;
        alu_op    = alu_from_funct3(funct3, fetch_instr[30], 1'b1);
`ifdef DECODE_ILLEGAL_CHECK_EN
        illegal = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
`endif
      end
      default: begin
`ifdef DECODE_ILLEGAL_CHECK_EN
        illegal = 1'b1;
`else
        illegal = 1'b0;
`endif
      end
    endcase
  end

  decode_imm_gen u_imm_gen (
    .instr (fetch_instr),
    .fmt   (imm_fmt),
    .imm   (imm)
  );

  // Flush beats stall beats capture; a bubble only clears the valid and write-enable.
  always_comb begin
    id_ex_d = id_ex_q;
    if (flush) begin
      id_ex_d.clk_en  = 1'b0;
      id_ex_d.wr_rd   = 1'b0;
      id_ex_d.illegal = 1'b0;
    end else if (!stall) begin
      if (fetch_clk_en) begin
        id_ex_d.pc       = fetch_pc;
        id_ex_d.rs1_addr = fetch_instr[19:15];
        id_ex_d.rs2_addr = fetch_instr[24:20];
        id_ex_d.rd_addr  = rd;
        id_ex_d.imm      = imm;
        id_ex_d.opcode   = opcode;
        id_ex_d.funct3   = funct3;
        id_ex_d.alu_op   = alu_op;
        id_ex_d.wr_rd    = writes_rd && (rd != 5'd0) && !illegal;
        id_ex_d.illegal  = illegal;
        id_ex_d.clk_en   = 1'b1;
      end else begin
        id_ex_d.clk_en = 1'b0;
        id_ex_d.wr_rd  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q    <= '0;
      id_ex_q.pc <= PC_RESET;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  // Synchronous regfile: while stalled, keep reading the held operands so data stays aligned.
  assign regfile_rs1_addr = stall ? id_ex_q.rs1_addr : fetch_instr[19:15];
  assign regfile_rs2_addr = stall ? id_ex_q.rs2_addr : fetch_instr[24:20];

  assign decode_pc       = id_ex_q.pc;
  assign decode_rs1_addr = id_ex_q.rs1_addr;
  assign decode_rs2_addr = id_ex_q.rs2_addr;
  assign decode_rd_addr  = id_ex_q.rd_addr;
  assign decode_imm      = id_ex_q.imm;
  assign decode_opcode   = id_ex_q.opcode;
  assign decode_funct3   = id_ex_q.funct3;
  assign decode_alu_op   = id_ex_q.alu_op;
  assign decode_wr_rd    = id_ex_q.wr_rd;
  assign decode_illegal  = id_ex_q.illegal;
  assign decode_clk_en   = id_ex_q.clk_en;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the RV32I decode stage.
module tb_decode;

  localparam logic [31:0] PcReset = 32'h0000_0100;

  localparam logic [31:0] InsAddi = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] InsSub  = 32'h4020_81B3;  // sub x3,x1,x2
  localparam logic [31:0] InsBeq  = 32'hFE00_0EE3;  // beq x0,x0,-4
  localparam logic [31:0] InsSw   = 32'h0020_A423;  // sw x2,8(x1)
  localparam logic [31:0] InsLui  = 32'h1234_52B7;  // lui x5,0x12345
  localparam logic [31:0] InsJal  = 32'h0010_00EF;  // jal x1,+2048
  localparam logic [31:0] InsSrai = 32'h4030_D213;  // srai x4,x1,3
  localparam logic [31:0] InsNop  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] InsBad  = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_clk_en;
  logic        stall;
  logic        flush;
  logic [4:0]  regfile_rs1_addr;
  logic [4:0]  regfile_rs2_addr;
  logic [31:0] decode_pc;
  logic [4:0]  decode_rs1_addr;
  logic [4:0]  decode_rs2_addr;
  logic [4:0]  decode_rd_addr;
  logic [31:0] decode_imm;
  logic [6:0]  decode_opcode;
  logic [2:0]  decode_funct3;
  logic [3:0]  decode_alu_op;
  logic        decode_wr_rd;
  logic        decode_illegal;
  logic        decode_clk_en;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode #(
    .PC_RESET (PcReset)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_instr      (fetch_instr),
    .fetch_pc         (fetch_pc),
    .fetch_clk_en     (fetch_clk_en),
    .stall            (stall),
    .flush            (flush),
    .regfile_rs1_addr (regfile_rs1_addr),
    .regfile_rs2_addr (regfile_rs2_addr),
    .decode_pc        (decode_pc),
    .decode_rs1_addr  (decode_rs1_addr),
    .decode_rs2_addr  (decode_rs2_addr),
    .decode_rd_addr   (decode_rd_addr),
    .decode_imm       (decode_imm),
    .decode_opcode    (decode_opcode),
    .decode_funct3    (decode_funct3),
    .decode_alu_op    (decode_alu_op),
    .decode_wr_rd     (decode_wr_rd),
    .decode_illegal   (decode_illegal),
    .decode_clk_en    (decode_clk_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic valid,
                       input logic stl, input logic fl, input logic rs);
    fetch_instr  = instr;
    fetch_pc     = pc;
    fetch_clk_en = valid;
    stall        = stl;
    flush        = fl;
    rst          = rs;
    #1;
  endtask

  initial begin
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check("rst_pc", decode_pc, PcReset);
    check("rst_clk_en", decode_clk_en, 0);
    check("rst_rd", decode_rd_addr, 0);
    check("rst_imm", decode_imm, 0);
    check("rst_wr_rd", decode_wr_rd, 0);
    check("rst_opcode", decode_opcode, 0);
    check("rst_alu", decode_alu_op, 0);
    check("rst_illegal", decode_illegal, 0);

    // addi
    drive(InsAddi, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("addi_rf_rs2_comb", regfile_rs2_addr, 5);
    tick();
    check("addi_clk_en", decode_clk_en, 1);
    check("addi_rd", decode_rd_addr, 1);
    check("addi_rs1", decode_rs1_addr, 0);
    check("addi_imm", decode_imm, 5);
    check("addi_alu", decode_alu_op, 0);
    check("addi_wr_rd", decode_wr_rd, 1);
    check("addi_opcode", decode_opcode, 7'h13);
    check("addi_pc", decode_pc, 32'h0);

    // sub
    drive(InsSub, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sub_rf_rs1_comb", regfile_rs1_addr, 1);
    check("sub_rf_rs2_comb", regfile_rs2_addr, 2);
    tick();
    check("sub_rs1", decode_rs1_addr, 1);
    check("sub_rs2", decode_rs2_addr, 2);
    check("sub_rd", decode_rd_addr, 3);
    check("sub_alu", decode_alu_op, 1);
    check("sub_wr_rd", decode_wr_rd, 1);
    check("sub_pc", decode_pc, 32'h4);

    // beq
    drive(InsBeq, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("beq_imm", decode_imm, 32'hFFFF_FFFC);
    check("beq_alu", decode_alu_op, 1);
    check("beq_wr_rd", decode_wr_rd, 0);
    check("beq_funct3", decode_funct3, 0);
    check("beq_opcode", decode_opcode, 7'h63);

    // bubble: valid/write cleared, payload held
    drive(InsSub, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("bub_clk_en", decode_clk_en, 0);
    check("bub_wr_rd", decode_wr_rd, 0);
    check("bub_imm_hold", decode_imm, 32'hFFFF_FFFC);
    check("bub_pc_hold", decode_pc, 32'h8);

    drive(InsSw, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("sw_imm", decode_imm, 32'h8);
    check("sw_alu", decode_alu_op, 0);
    check("sw_wr_rd", decode_wr_rd, 0);
    check("sw_funct3", decode_funct3, 2);

    drive(InsLui, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("lui_imm", decode_imm, 32'h1234_5000);
    check("lui_alu", decode_alu_op, 10);
    check("lui_rd", decode_rd_addr, 5);
    check("lui_wr_rd", decode_wr_rd, 1);

    drive(InsJal, 32'h18, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("jal_imm", decode_imm, 32'h800);
    check("jal_alu", decode_alu_op, 0);
    check("jal_wr_rd", decode_wr_rd, 1);

    drive(InsSrai, 32'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("srai_alu", decode_alu_op, 7);
    check("srai_imm", decode_imm, 32'h403);
    check("srai_rd", decode_rd_addr, 4);
    check("srai_wr_rd", decode_wr_rd, 1);

    drive(InsNop, 32'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("nop_wr_rd_x0", decode_wr_rd, 0);
    check("nop_clk_en", decode_clk_en, 1);

    // stall: capture addi, hold three cycles while fetch shows sub
    drive(InsAddi, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(InsSub, 32'h24, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stl_rf_rs1", regfile_rs1_addr, 0);
      check("stl_rf_rs2", regfile_rs2_addr, 5);
      tick();
      check("stl_rd_hold", decode_rd_addr, 1);
      check("stl_pc_hold", decode_pc, 32'h20);
      check("stl_clk_en_hold", decode_clk_en, 1);
    end
    drive(InsSub, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rel_rf_rs1", regfile_rs1_addr, 1);
    tick();
    check("rel_rd", decode_rd_addr, 3);
    check("rel_pc", decode_pc, 32'h24);
    check("rel_alu", decode_alu_op, 1);

    // flush beats stall and valid
    drive(InsAddi, 32'h28, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("fl_clk_en", decode_clk_en, 0);
    check("fl_wr_rd", decode_wr_rd, 0);
    check("fl_illegal", decode_illegal, 0);
    check("fl_pc_hold", decode_pc, 32'h24);

    // reset beats flush
    drive(InsAddi, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_rf_rd", decode_rd_addr, 1);
    drive(InsAddi, 32'h30, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("rf_pc", decode_pc, PcReset);
    check("rf_rd", decode_rd_addr, 0);
    check("rf_imm", decode_imm, 0);

    // reset mid-stall
    drive(InsSub, 32'h34, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_rs_clk_en", decode_clk_en, 1);
    drive(InsSub, 32'h34, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("rs_clk_en", decode_clk_en, 0);
    check("rs_rs1", decode_rs1_addr, 0);
    check("rs_pc", decode_pc, PcReset);
    check("rs_alu", decode_alu_op, 0);

    // unknown opcode
    drive(InsBad, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("bad_clk_en", decode_clk_en, 1);
    check("bad_wr_rd", decode_wr_rd, 0);
    check("bad_alu", decode_alu_op, 0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    check("bad_illegal", decode_illegal, 1);
    drive(InsAddi, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("bad_flush_illegal", decode_illegal, 0);
`else
    check("bad_illegal", decode_illegal, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
